// File: rtl/reg_file_bypass_if.sv
// Bus bundle for reg_file_bypass: write port, two read ports and the bulk-clear handshake.
// The master drives addresses, data and requests; the slave (the register file) returns read data and status.
interface reg_file_bypass_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             clr_req;
    logic             clr_busy;
    logic             clr_done;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr_req,
        input  rdata_a, rdata_b, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
        output rdata_a, rdata_b, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_bypass.sv
// General-purpose register bank: 2**AW x WIDTH, one write port, two combinational read ports
// with write-through forwarding, plus a one-register-per-cycle bulk-clear sweep.
module reg_file_bypass #(
    parameter int WIDTH    = 16,
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input logic             clk,
    input logic             rst_b,
    reg_file_bypass_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             clr_busy_q, clr_busy_d;
    logic             clr_done_q, clr_done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             wr_ok;
    logic             fwd_ok;
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    // Sweep control; the index wraps to 0 on the same edge that leaves CLEAR.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        clr_busy_d = (state_d == CLEAR);
        clr_done_d = (state_d == DONE);
    end

    assign wr_ok = bus.we && (state_q != CLEAR) && !(ZERO_REG && (bus.waddr == '0));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (state_q == CLEAR) begin
                if (idx_q == AW'(i)) begin
                    mem_d[i] = '0;
                end
            end else if (wr_ok && (bus.waddr == AW'(i))) begin
                mem_d[i] = bus.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Forwarding is held off during reset so both read ports show 0 while rst_b is low.
    assign fwd_ok   = BYPASS && rst_b && bus.we && (state_q != CLEAR);
    assign raddr[0] = bus.raddr_a;
    assign raddr[1] = bus.raddr_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (ZERO_REG && (raddr[gi] == '0))        ? '0 :
                               (fwd_ok && (bus.waddr == raddr[gi]))   ? bus.wdata :
                                                                        mem_q[raddr[gi]];
        end
    endgenerate

    assign bus.rdata_a  = rdata[0];
    assign bus.rdata_b  = rdata[1];
    assign bus.clr_busy = clr_busy_q;
    assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_reg_file_bypass.sv
// Drives two register-file variants (forwarding/no zero-reg and no forwarding/zero-reg) with the
// same stimulus and compares them to an array-based model of the register bank and clear sweep.
module tb_reg_file_bypass;
    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b;
    logic          we;
    logic          clr_req;
    logic [AW-1:0] waddr, raddr_a, raddr_b;
    logic [W-1:0]  wdata;

    reg_file_bypass_if #(.WIDTH(W), .AW(AW)) if0 ();
    reg_file_bypass_if #(.WIDTH(W), .AW(AW)) if1 ();

    assign if0.we = we;           assign if1.we = we;
    assign if0.waddr = waddr;     assign if1.waddr = waddr;
    assign if0.wdata = wdata;     assign if1.wdata = wdata;
    assign if0.raddr_a = raddr_a; assign if1.raddr_a = raddr_a;
    assign if0.raddr_b = raddr_b; assign if1.raddr_b = raddr_b;
    assign if0.clr_req = clr_req; assign if1.clr_req = clr_req;

    reg_file_bypass #(.WIDTH(W), .AW(AW), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
        .clk(clk), .rst_b(rst_b), .bus(if0.slave));
    reg_file_bypass #(.WIDTH(W), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_b(rst_b), .bus(if1.slave));

    logic [W-1:0] got_a [2];
    logic [W-1:0] got_b [2];
    logic         got_busy [2];
    logic         got_done [2];
    assign got_a[0] = if0.rdata_a;     assign got_a[1] = if1.rdata_a;
    assign got_b[0] = if0.rdata_b;     assign got_b[1] = if1.rdata_b;
    assign got_busy[0] = if0.clr_busy; assign got_busy[1] = if1.clr_busy;
    assign got_done[0] = if0.clr_done; assign got_done[1] = if1.clr_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: stored contents per variant, plus "clear cycles remaining" and a done flag.
    logic [W-1:0] mdl [2][DEPTH];
    int           sweep_left;
    bit           done_now;

    function automatic bit zr(int d); return d == 1; endfunction
    function automatic bit bp(int d); return d == 0; endfunction

    function automatic logic [W-1:0] exp_rd(int d, logic [AW-1:0] a);
        if (rst_b !== 1'b1) return '0;
        if (zr(d) && a == 0) return '0;
        if (bp(d) && we && sweep_left == 0 && waddr == a) return wdata;
        return mdl[d][a];
    endfunction

    function automatic logic exp_busy();
        return (rst_b === 1'b1) && (sweep_left > 0);
    endfunction

    function automatic logic exp_done();
        return (rst_b === 1'b1) && done_now;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
        sweep_left = 0;
        done_now   = 1'b0;
    endtask

    // Advance the model by one rising edge, then move to just after that edge.
    task automatic tick();
        if (rst_b === 1'b1) begin
            if (sweep_left > 0) begin
                for (int d = 0; d < 2; d++) mdl[d][DEPTH - sweep_left] = '0;
                sweep_left--;
                if (sweep_left == 0) done_now = 1'b1;
            end else begin
                for (int d = 0; d < 2; d++)
                    if (we && !(zr(d) && waddr == 0)) mdl[d][waddr] = wdata;
                if (done_now) done_now = 1'b0;
                else if (clr_req) sweep_left = DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; clr_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; waddr = AW'(a); wdata = W'($urandom);
            raddr_a = AW'(a); raddr_b = AW'(DEPTH - 1 - a);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_a[d] !== '0 || got_b[d] !== '0) begin
                    miscompares++;
                    $display("FAIL reset_read dut%0d addr %0d: got a=%h b=%h want 0", d, a, got_a[d], got_b[d]);
                end
                vectors++;
                if (got_busy[d] !== 1'b0 || got_done[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_status dut%0d: got busy=%b done=%b want 0 0", d, got_busy[d], got_done[d]);
                end
            end
            $display("reset read addr %0d/%0d", a, DEPTH - 1 - a);
        end
        we = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; raddr_a = 4'd1; raddr_b = 4'd2;
        tick();
        we = 1'b0; raddr_a = 4'd5; raddr_b = 4'd5;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got_a[d] !== 16'hBEEF || got_b[d] !== 16'hBEEF) begin
                miscompares++;
                $display("FAIL write_read dut%0d r5: got a=%h b=%h want beef", d, got_a[d], got_b[d]);
            end
        end
        $display("write r5=beef, read back");
        tick();
    endtask

    task automatic test_bypass();
        logic [W-1:0] old3, old4;
        old3 = W'($urandom); old4 = W'($urandom);
        if (old3 == 16'h1234) old3 = 16'h5555;
        we = 1'b1; waddr = 4'd3; wdata = old3; tick();
        waddr = 4'd4; wdata = old4; tick();
        waddr = 4'd3; wdata = 16'h1234; raddr_a = 4'd3; raddr_b = 4'd4;
        #1;
        vectors++;
        if (got_a[0] !== 16'h1234) begin
            miscompares++;
            $display("FAIL bypass_a dut0: got %h want 1234", got_a[0]);
        end
        vectors++;
        if (got_a[1] !== old3) begin
            miscompares++;
            $display("FAIL nobypass_a dut1: got %h want %h", got_a[1], old3);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got_b[d] !== old4) begin
                miscompares++;
                $display("FAIL bypass_b_other dut%0d: got %h want %h", d, got_b[d], old4);
            end
        end
        $display("bypass write r3=1234 with old r3=%h r4=%h", old3, old4);
        tick();
        we = 1'b0; raddr_a = 4'd3; raddr_b = 4'd3;
        #1;
        // Both ports forwarding in the same cycle on the forwarding variant.
        we = 1'b1; waddr = 4'd9; wdata = 16'hC0DE; raddr_a = 4'd9; raddr_b = 4'd9;
        #1;
        vectors++;
        if (got_a[0] !== 16'hC0DE || got_b[0] !== 16'hC0DE) begin
            miscompares++;
            $display("FAIL dual_bypass dut0: got a=%h b=%h want c0de", got_a[0], got_b[0]);
        end
        $display("dual bypass r9=c0de");
        tick();
        we = 1'b0;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; raddr_a = 4'd0; raddr_b = 4'd0;
        #1;
        vectors++;
        if (got_a[1] !== 16'h0000 || got_b[1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_reg_wcycle dut1: got a=%h b=%h want 0", got_a[1], got_b[1]);
        end
        vectors++;
        if (got_a[0] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL r0_bypass dut0: got %h want ffff", got_a[0]);
        end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (got_a[1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_reg_after dut1: got %h want 0", got_a[1]);
        end
        vectors++;
        if (got_a[0] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL r0_stored dut0: got %h want ffff", got_a[0]);
        end
        $display("write r0=ffff: dut0 %h dut1 %h", got_a[0], got_a[1]);
        tick();
    endtask

    task automatic test_random();
        clr_req = 1'b0;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom); waddr = AW'($urandom); wdata = W'($urandom);
            raddr_a = ($urandom_range(0, 1) == 1) ? waddr : AW'($urandom);
            raddr_b = AW'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_a[d] !== exp_rd(d, raddr_a) || got_b[d] !== exp_rd(d, raddr_b)) begin
                    miscompares++;
                    $display("FAIL random_rd dut%0d a[%0d]=%h want %h b[%0d]=%h want %h", d, raddr_a,
                             got_a[d], exp_rd(d, raddr_a), raddr_b, got_b[d], exp_rd(d, raddr_b));
                end
            end
            $display("rand %0d we=%b wa=%0d wd=%h ra=%0d rb=%0d", n, we, waddr, wdata, raddr_a, raddr_b);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_bulk_clear();
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = W'(16'hA0 + i); tick();
        end
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            we = (c < DEPTH) ? 1'($urandom) : 1'b0;
            waddr = AW'($urandom); wdata = W'($urandom);
            raddr_a = AW'($urandom); raddr_b = AW'($urandom);
            if (c == 8) begin raddr_a = 4'd7; raddr_b = 4'd8; end
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_busy[d] !== (c < DEPTH) || got_done[d] !== (c == DEPTH)) begin
                    miscompares++;
                    $display("FAIL clear_timeline dut%0d cycle T+%0d: got busy=%b done=%b want %b %b",
                             d, c, got_busy[d], got_done[d], c < DEPTH, c == DEPTH);
                end
                vectors++;
                if (got_a[d] !== exp_rd(d, raddr_a) || got_b[d] !== exp_rd(d, raddr_b)) begin
                    miscompares++;
                    $display("FAIL clear_rd dut%0d a[%0d]=%h want %h b[%0d]=%h want %h", d, raddr_a,
                             got_a[d], exp_rd(d, raddr_a), raddr_b, got_b[d], exp_rd(d, raddr_b));
                end
            end
            if (c == 8) begin
                vectors++;
                if (got_a[0] !== 16'h0000 || got_b[0] !== 16'h00A8) begin
                    miscompares++;
                    $display("FAIL mid_sweep dut0: got r7=%h r8=%h want 0 a8", got_a[0], got_b[0]);
                end
            end
            $display("clear T+%0d busy=%b done=%b we=%b", c, got_busy[0], got_done[0], we);
            tick();
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            raddr_a = AW'(a); raddr_b = AW'(a + 1);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_a[d] !== '0 || got_b[d] !== '0) begin
                    miscompares++;
                    $display("FAIL post_clear dut%0d r%0d=%h r%0d=%h want 0", d, a, got_a[d], a + 1, got_b[d]);
                end
            end
            $display("post clear r%0d/r%0d", a, a + 1);
            tick();
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = W'($urandom_range(1, 16'hFFFF)); tick();
        end
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        raddr_a = 4'd12; raddr_b = 4'd15;
        rst_b = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got_busy[d] !== 1'b0 || got_a[d] !== '0 || got_b[d] !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_sweep dut%0d: got busy=%b a=%h b=%h want 0 0 0", d, got_busy[d], got_a[d], got_b[d]);
            end
        end
        $display("reset during 6th clear cycle");
        #2;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < DEPTH + 4; c++) begin
            raddr_a = AW'(c); raddr_b = AW'(c + 3);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_done[d] !== 1'b0 || got_busy[d] !== 1'b0 || got_a[d] !== '0 || got_b[d] !== '0) begin
                    miscompares++;
                    $display("FAIL after_reset dut%0d cycle %0d: got done=%b busy=%b a=%h b=%h want all 0",
                             d, c, got_done[d], got_busy[d], got_a[d], got_b[d]);
                end
            end
            $display("after reset cycle %0d", c);
            tick();
        end
    endtask

    task automatic test_held_req();
        int starts [$];
        int busy_len;
        logic prev;
        prev = 1'b0; busy_len = 0;
        we = 1'b0; clr_req = 1'b1;
        for (int k = 0; k < 45; k++) begin
            raddr_a = AW'($urandom); raddr_b = AW'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (got_busy[d] !== exp_busy() || got_done[d] !== exp_done()) begin
                    miscompares++;
                    $display("FAIL held_status dut%0d cycle %0d: got busy=%b done=%b want %b %b",
                             d, k, got_busy[d], got_done[d], exp_busy(), exp_done());
                end
            end
            if (got_busy[0] === 1'b1 && !prev) starts.push_back(k);
            if (got_busy[0] === 1'b1 && starts.size() == 1) busy_len++;
            prev = got_busy[0];
            $display("held cycle %0d busy=%b done=%b", k, got_busy[0], got_done[0]);
            tick();
        end
        vectors++;
        if (starts.size() < 2 || (starts[1] - starts[0]) != 18 || busy_len != DEPTH) begin
            miscompares++;
            $display("FAIL held_period: got %0d starts, period %0d, busy run %0d; want period 18, busy 16",
                     starts.size(), (starts.size() >= 2) ? starts[1] - starts[0] : -1, busy_len);
        end
        clr_req = 1'b0;
        for (int k = 0; k < 40 && (sweep_left > 0 || done_now); k++) tick();
        #1;
        vectors++;
        if (got_busy[0] !== 1'b0 || got_done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL held_drain: got busy=%b done=%b want 0 0", got_busy[0], got_done[0]);
        end
    endtask

    initial begin
        we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; clr_req = 1'b0; rst_b = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_random();
        test_bulk_clear();
        test_reset_mid_sweep();
        test_held_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Parametrised multi-register file that succeeds the single 16-bit bypass register.
- Holds 2**AW registers of WIDTH bits, with one write port and two combinational read ports.
- Each read port has write-through bypass, so a value written this cycle is readable in the same cycle.
- A sequential bulk-clear engine zeroes the whole file one register per cycle. The block serves as the processor's general-purpose register bank.

Parameters:
- WIDTH, 16: bits per register.
- AW, 4: address width; depth DEPTH = 2**AW registers.
- ZERO_REG, 0: if 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: if 1, write-to-read forwarding is enabled; if 0, reads always return stored contents.

Ports:
- clk  in  1  rising-edge clock.
- rst_b  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  read data, port A (combinational).
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  read data, port B (combinational).
- clr_req  in  1  bulk-clear request, level-sampled.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (rst_b=0, asynchronous): all registers are 0, FSM goes to IDLE, sweep index is 0, clr_busy=0, clr_done=0. rdata_a and rdata_b are 0 while reset is held.
- Write: when we=1 and the FSM is IDLE or DONE, reg[waddr] <= wdata on the next rising edge; latency is 1 edge. When ZERO_REG=1 and waddr=0, the write is discarded.
- Read: rdata_x = reg[raddr_x], combinational.
- Bypass: applies when BYPASS=1, we=1, the FSM is not CLEAR, waddr==raddr_x, and it is not the case that (ZERO_REG=1 and raddr_x=0).
  - In that case rdata_x = wdata in the same cycle.
  - Both ports may bypass simultaneously.
- Zero register: when ZERO_REG=1 and raddr_x=0, rdata_x=0 always, with priority over bypass.
- FSM states:
  - IDLE: clr_busy=0, clr_done=0. If clr_req=1 at an edge, go to CLEAR with idx=0. A we in the same cycle as clr_req is still performed at that edge.
  - CLEAR: clr_busy=1. At each edge reg[idx] <= 0 and idx <= idx+1. After the edge that clears idx=DEPTH-1, go to DONE. CLEAR lasts exactly DEPTH cycles.
    - External we is ignored and bypass is disabled.
    - Reads return stored contents, so partially cleared values are visible.
    - clr_req is ignored.
  - DONE: lasts exactly 1 cycle, with clr_done=1 and clr_busy=0, then goes to IDLE.
    - External writes and bypass operate normally.
    - clr_req is ignored in DONE; it is sampled again from IDLE.
- Index wrap: idx is AW bits wide, and the wrap from DEPTH-1 to 0 coincides with the CLEAR->DONE transition.
- Reset asserted mid-sweep: everything is zeroed immediately, the FSM returns to IDLE, and no clr_done pulse is produced.
- Held request: if clr_req stays high, a new sweep starts from IDLE one cycle after DONE.
- Output registration: clr_busy and clr_done are decoded from FSM state registers, so they are glitch-free.

Test Plan:
- Reset then read: read all addresses on both ports -> 0. Write 0xBEEF to r5, then read r5 next cycle on A and B -> 0xBEEF.
- Bypass: we=1, waddr=3, wdata=0x1234, raddr_a=3, raddr_b=4, in the same cycle -> rdata_a=0x1234, rdata_b=old r4.
  - Rerun with BYPASS=0 -> rdata_a=old r3 until the edge.
- Zero register: with ZERO_REG=1, write 0xFFFF to r0 -> r0 reads 0, including in the write cycle.
  - With ZERO_REG=0 -> reads 0xFFFF after the edge and via bypass.
- Bulk clear: load all 16 registers with 0xA0+i, then pulse clr_req at edge T.
  - clr_busy is high for cycles T..T+15, and r0..r7 are read 0 by mid-sweep while r8..r15 are still 0xA8..0xAF.
  - clr_done is high exactly in cycle T+16, then all registers are 0.
  - we issued during CLEAR has no effect.
- Reset mid-sweep: assert rst_b=0 during the 6th CLEAR cycle -> clr_busy=0 immediately, all registers 0, no clr_done pulse.
- Held clr_req: keep clr_req high -> busy for 16 cycles, done for 1 cycle, idle for 1 cycle, then busy again. Verify the period is 18 cycles.
